// File: rtl/kernel3_gmem_a_axi_rd_responder_if.sv
// AXI4 read-channel bundle (AR + R) between the gmem_A read master and the read responder.
// Every channel transfers on a clock edge where both VALID and READY are high. VALID never waits on READY,
// and once VALID is high the payload stays stable until the transfer.
interface kernel3_gmem_a_axi_rd_responder_if #(
    parameter int C_ID_WIDTH     = 1,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 32
);
    logic [C_ID_WIDTH-1:0]     ARID;
    logic [BUS_ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [C_ID_WIDTH-1:0]     RID;
    logic [BUS_DATA_WIDTH-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/kernel3_gmem_a_axi_rd_responder.sv
// AXI4 read responder for the gmem_A path: queues AR bursts and streams R beats from an internal
// word-addressed memory, in order, one beat per cycle, through a registered 2-entry output buffer.
module kernel3_gmem_a_axi_rd_responder #(
    parameter int C_ID_WIDTH      = 1,
    parameter int BUS_ADDR_WIDTH  = 32,
    parameter int BUS_DATA_WIDTH  = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int NUM_OUTSTANDING = 4,
    localparam int MEM_AW         = $clog2(MEM_DEPTH)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      ACLK_EN,
    kernel3_gmem_a_axi_rd_responder_if.slave bus,
    input  logic                      in_MEM_WE,
    input  logic [MEM_AW-1:0]         in_MEM_ADDR,
    input  logic [BUS_DATA_WIDTH-1:0] in_MEM_WDATA,
    output logic [0:0]                dbg_state
);
    localparam int ALIGN = $clog2(BUS_DATA_WIDTH / 8);
    localparam int WW    = BUS_ADDR_WIDTH - ALIGN;
    localparam int QAW   = $clog2(NUM_OUTSTANDING);

    typedef struct packed {
        logic [C_ID_WIDTH-1:0] id;
        logic [WW-1:0]         word;
        logic [7:0]            len;
        logic                  err;
    } req_t;

    typedef struct packed {
        logic [C_ID_WIDTH-1:0]     id;
        logic [BUS_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } beat_t;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    req_t                      q_mem [NUM_OUTSTANDING];
    logic [QAW-1:0]            wr_ptr, rd_ptr;
    logic [QAW:0]              q_cnt, q_cnt_d;
    logic                      arready_q;
    logic                      push, pop_req, load, issue, room, q_empty, r_pop;
    req_t                      req_in, head, src, cur_q;
    beat_t                     beat_new, o_q, s_q;
    logic [1:0]                o_cnt;

    assign push    = ACLK_EN & bus.ARVALID & arready_q;
    assign q_empty = (q_cnt == '0);
    assign head    = q_mem[rd_ptr];
    assign room    = (o_cnt < 2'd2);
    assign r_pop   = (o_cnt != 2'd0) & bus.RREADY;
    assign q_cnt_d = q_cnt + (QAW+1)'(push) - (QAW+1)'(pop_req);

    always_comb begin
        req_in.id   = bus.ARID;
        req_in.word = bus.ARADDR[BUS_ADDR_WIDTH-1:ALIGN];
        req_in.len  = bus.ARLEN;
        req_in.err  = (bus.ARSIZE != 3'(ALIGN)) | (bus.ARBURST != 2'b01);
    end

    always_ff @(posedge ACLK) begin
        if (in_MEM_WE) mem[in_MEM_ADDR] <= in_MEM_WDATA;
    end

    always_ff @(posedge ACLK) begin
        if (push) q_mem[wr_ptr] <= req_in;
    end

    // ARREADY comes from a registered full flag, so a pop never opens the door in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            arready_q <= 1'b0;
        end else if (ACLK_EN) begin
            if (push)    wr_ptr <= wr_ptr + QAW'(1);
            if (pop_req) rd_ptr <= rd_ptr + QAW'(1);
            q_cnt     <= q_cnt_d;
            arready_q <= (q_cnt_d != (QAW+1)'(NUM_OUTSTANDING));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET)       state_q <= S_IDLE;
        else if (ACLK_EN) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!q_empty) state_d = (room && head.len == 8'd0) ? S_IDLE : S_BURST;
            S_BURST: if (room && cur_q.len == 8'd0) state_d = q_empty ? S_IDLE : S_BURST;
            default: state_d = S_IDLE;
        endcase
    end

    // In IDLE the first beat is taken straight from the queue head so an idle block answers in two cycles.
    always_comb begin
        issue   = 1'b0;
        pop_req = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    pop_req = 1'b1;
                    load    = 1'b1;
                    issue   = room;
                end
            end
            S_BURST: begin
                issue = room;
                if (room && cur_q.len == 8'd0 && !q_empty) begin
                    pop_req = 1'b1;
                    load    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        src           = (state_q == S_IDLE) ? head : cur_q;
        beat_new.id   = src.id;
        beat_new.last = (src.len == 8'd0);
        beat_new.data = '0;
        if (src.err) begin
            beat_new.resp = 2'b10;
        end else if (src.word >= WW'(MEM_DEPTH)) begin
            beat_new.resp = 2'b11;
        end else begin
            beat_new.resp = 2'b00;
            beat_new.data = mem[src.word[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cur_q <= '0;
        end else if (ACLK_EN) begin
            if (load && state_q == S_IDLE && issue) begin
                cur_q      <= head;
                cur_q.word <= head.word + WW'(1);
                cur_q.len  <= head.len - 8'd1;
            end else if (load) begin
                cur_q <= head;
            end else if (issue) begin
                cur_q.word <= cur_q.word + WW'(1);
                cur_q.len  <= cur_q.len - 8'd1;
            end
        end
    end

    // o_q drives the bus; s_q catches the one beat that may land while the consumer stalls.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            o_q   <= '0;
            s_q   <= '0;
            o_cnt <= 2'd0;
        end else if (ACLK_EN) begin
            case (o_cnt)
                2'd0: if (issue) begin
                    o_q   <= beat_new;
                    o_cnt <= 2'd1;
                end
                2'd1: begin
                    if (r_pop) begin
                        if (issue) o_q <= beat_new;
                        else       o_cnt <= 2'd0;
                    end else if (issue) begin
                        s_q   <= beat_new;
                        o_cnt <= 2'd2;
                    end
                end
                default: if (r_pop) begin
                    o_q   <= s_q;
                    o_cnt <= 2'd1;
                end
            endcase
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = (o_cnt != 2'd0);
    assign bus.RID     = o_q.id;
    assign bus.RDATA   = o_q.data;
    assign bus.RRESP   = o_q.resp;
    assign bus.RLAST   = o_q.last;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_kernel3_gmem_a_axi_rd_responder.sv
// Directed bench for the gmem_A read responder: latency, back-to-back bursts, backpressure,
// out-of-range and malformed requests, clock enable and mid-burst reset.
module tb_kernel3_gmem_a_axi_rd_responder;
    localparam int IDW = 1;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MD  = 1024;
    localparam int MAW = 10;
    localparam int BW  = IDW + DW + 2 + 1;

    logic           ACLK = 1'b0;
    logic           ARESET = 1'b1;
    logic           ACLK_EN = 1'b1;
    logic           in_MEM_WE = 1'b0;
    logic [MAW-1:0] in_MEM_ADDR = '0;
    logic [DW-1:0]  in_MEM_WDATA = '0;
    logic [0:0]     dbg_state;

    kernel3_gmem_a_axi_rd_responder_if #(.C_ID_WIDTH(IDW), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW)) bus ();

    kernel3_gmem_a_axi_rd_responder #(
        .C_ID_WIDTH(IDW), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .MEM_DEPTH(MD), .NUM_OUTSTANDING(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ACLK_EN(ACLK_EN), .bus(bus.slave),
        .in_MEM_WE(in_MEM_WE), .in_MEM_ADDR(in_MEM_ADDR), .in_MEM_WDATA(in_MEM_WDATA),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 ACLK = ~ACLK;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int            obs_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input int id, input int data, input int resp, input int last);
        return {IDW'(id), DW'(data), 2'(resp), 1'(last)};
    endfunction

    // R monitor: records every transfer and checks that a stalled beat stays put
    logic [BW-1:0] cur_beat;
    logic [BW-1:0] held = '0;
    logic          pend = 1'b0;
    assign cur_beat = {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};

    always @(negedge ACLK) begin
        if (ARESET) begin
            pend = 1'b0;
        end else if (ACLK_EN) begin
            if (pend) begin
                check("r_hold_valid", 64'(bus.RVALID), 64'd1);
                check("r_hold_beat", 64'(cur_beat), 64'(held));
            end
            pend = bus.RVALID && !bus.RREADY;
            held = cur_beat;
            if (bus.RVALID && bus.RREADY) begin
                obs_q.push_back(cur_beat);
                obs_cyc.push_back(cyc + 1);
            end
        end
    end

    // driver tasks (all start and end at posedge+1)
    task automatic ar_send(input int id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst, output int t_hs);
        bit hs = 0;
        int guard = 0;
        bus.ARID = IDW'(id); bus.ARADDR = addr; bus.ARLEN = 8'(len);
        bus.ARSIZE = 3'(size); bus.ARBURST = 2'(burst); bus.ARVALID = 1'b1;
        while (!hs && guard < 60) begin
            @(negedge ACLK);
            hs = bus.ARREADY && ACLK_EN;
            @(posedge ACLK); #1;
            guard++;
        end
        if (!hs) check("ar_timeout", 64'd0, 64'd1);
        t_hs = cyc;
    endtask

    task automatic ar_idle();
        bus.ARVALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (obs_q.size() < exp_q.size() && guard < 300) begin
            @(posedge ACLK); #1;
            guard++;
        end
        repeat (4) begin @(posedge ACLK); #1; end
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_beat"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    int t;
    logic [3:0] pat = 4'b1001;

    initial begin
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'd2;
        bus.ARBURST = 2'b01; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_arready", 64'(bus.ARREADY), 64'd0);
        check("rst_rvalid", 64'(bus.RVALID), 64'd0);
        check("rst_rlast", 64'(bus.RLAST), 64'd0);
        check("rst_rid", 64'(bus.RID), 64'd0);
        check("rst_rresp", 64'(bus.RRESP), 64'd0);
        check("rst_rdata", 64'(bus.RDATA), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); @(negedge ACLK);
        check("rst_arready_after", 64'(bus.ARREADY), 64'd1);
        @(posedge ACLK); #1;

        // preload mem[i] = i
        for (int i = 0; i < MD; i++) begin
            in_MEM_WE = 1'b1; in_MEM_ADDR = MAW'(i); in_MEM_WDATA = DW'(i);
            @(posedge ACLK); #1;
        end
        in_MEM_WE = 1'b0;

        // 1: single burst latency and data
        ar_send(1, 32'h10, 3, 2, 1, t);
        ar_idle();
        for (int i = 0; i < 4; i++) exp_q.push_back(beat(1, 4 + i, 0, i == 3));
        repeat (8) begin @(posedge ACLK); #1; end
        for (int i = 0; i < 4; i++)
            check("t1_cycle", 64'(obs_cyc.size() > i ? obs_cyc[i] : -1), 64'(t + 2 + i));
        drain("t1");

        // clock enable low: no handshake, FSM stays idle
        ACLK_EN = 1'b0;
        bus.ARID = 1'b0; bus.ARADDR = 32'h20; bus.ARLEN = 8'd1; bus.ARVALID = 1'b1;
        repeat (3) begin @(posedge ACLK); #1; end
        check("en_state", 64'(dbg_state), 64'd0);
        check("en_no_beats", 64'(obs_q.size()), 64'd0);
        ACLK_EN = 1'b1;
        ar_send(0, 32'h20, 1, 2, 1, t);
        ar_idle();
        exp_q.push_back(beat(0, 8, 0, 0));
        exp_q.push_back(beat(0, 9, 0, 1));
        drain("en");

        // 2a: four back-to-back bursts LEN 0..3
        for (int k = 0; k < 4; k++) begin
            ar_send(k & 1, AW'((20 + 10 * k) << 2), k, 2, 1, t);
            for (int j = 0; j <= k; j++) exp_q.push_back(beat(k & 1, 20 + 10 * k + j, 0, j == k));
        end
        ar_idle();
        repeat (16) begin @(posedge ACLK); #1; end
        for (int i = 1; i < 10; i++)
            check("t2_contig", 64'(obs_cyc.size() > i ? obs_cyc[i] - obs_cyc[0] : -1), 64'(i));
        drain("t2a");

        // 2b: fill the pipeline and queue with RREADY low, then watch ARREADY drop
        bus.RREADY = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ar_send(k & 1, AW'((100 + k) << 2), 0, 2, 1, t);
            exp_q.push_back(beat(k & 1, 100 + k, 0, 1));
        end
        bus.ARID = 1'b1; bus.ARADDR = AW'(107 << 2); bus.ARLEN = 8'd0; bus.ARVALID = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            check("t2_full_arready", 64'(bus.ARREADY), 64'd0);
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b1;
        ar_send(1, AW'(107 << 2), 0, 2, 1, t);
        ar_idle();
        exp_q.push_back(beat(1, 107, 0, 1));
        drain("t2b");

        // 3: LEN=15 burst under a 1,0,0,1 RREADY pattern
        ar_send(0, AW'(200 << 2), 15, 2, 1, t);
        ar_idle();
        for (int i = 0; i < 16; i++) exp_q.push_back(beat(0, 200 + i, 0, i == 15));
        for (int k = 0; k < 120 && obs_q.size() < 16; k++) begin
            bus.RREADY = pat[k % 4];
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b1;
        drain("t3");

        // 4: burst running off the end of memory
        ar_send(1, AW'((MD - 2) << 2), 3, 2, 1, t);
        ar_idle();
        exp_q.push_back(beat(1, MD - 2, 0, 0));
        exp_q.push_back(beat(1, MD - 1, 0, 0));
        exp_q.push_back(beat(1, 0, 3, 0));
        exp_q.push_back(beat(1, 0, 3, 1));
        drain("t4");

        // 5: bad size, bad burst type, then a good request
        ar_send(0, 32'h40, 1, 1, 1, t);
        ar_send(1, 32'h44, 0, 2, 2, t);
        ar_send(0, 32'h40, 0, 2, 1, t);
        ar_idle();
        exp_q.push_back(beat(0, 0, 2, 0));
        exp_q.push_back(beat(0, 0, 2, 1));
        exp_q.push_back(beat(1, 0, 2, 1));
        exp_q.push_back(beat(0, 16, 0, 1));
        drain("t5");

        // 6: reset in the middle of a LEN=7 burst with two requests queued
        ar_send(0, AW'(300 << 2), 7, 2, 1, t);
        ar_send(1, AW'(310 << 2), 0, 2, 1, t);
        ar_send(0, AW'(320 << 2), 0, 2, 1, t);
        ar_idle();
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        obs_q.delete(); obs_cyc.delete();
        @(posedge ACLK); @(negedge ACLK);
        check("t6_rst_rvalid", 64'(bus.RVALID), 64'd0);
        check("t6_rst_arready", 64'(bus.ARREADY), 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); @(negedge ACLK);
        check("t6_arready", 64'(bus.ARREADY), 64'd1);
        check("t6_rvalid", 64'(bus.RVALID), 64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        @(posedge ACLK); #1;
        repeat (12) begin @(posedge ACLK); #1; end
        check("t6_stale", 64'(obs_q.size()), 64'd0);
        ar_send(1, 32'h14, 0, 2, 1, t);
        ar_idle();
        exp_q.push_back(beat(1, 5, 0, 1));
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
